// File: rtl/char_pkg.sv
// rtl/char_pkg.sv - shared constants and 8x8 font for the character string renderer
package char_pkg;

    localparam int CODE_W     = 6;
    localparam int GLYPH_W    = 8;
    localparam int GLYPH_H    = 8;
    localparam int NUM_GLYPHS = 37;

    localparam logic [CODE_W-1:0] CODE_SPACE = CODE_W'(36);

    // One 64-bit word per glyph: row 0 in the top byte, bit 7 of each byte is the leftmost dot
    localparam logic [63:0] FONT [NUM_GLYPHS] = '{
        64'h3C666E7666663C00, // 0
        64'h1838181818187E00, // 1
        64'h3C66060C30607E00, // 2
        64'h3C66061C06663C00, // 3
        64'h0C1C3C6C7E0C0C00, // 4
        64'h7E607C0606663C00, // 5
        64'h3C607C6666663C00, // 6
        64'h7E060C1830303000, // 7
        64'h3C66663C66663C00, // 8
        64'h3C66663E060C3800, // 9
        64'h183C66667E666600, // A
        64'h7C66667C66667C00, // B
        64'h3C66606060663C00, // C
        64'h786C6666666C7800, // D
        64'h7E60607860607E00, // E
        64'h7E60607860606000, // F
        64'h3C66606E66663C00, // G
        64'h6666667E66666600, // H
        64'h3C18181818183C00, // I
        64'h1E0C0C0C0C6C3800, // J
        64'h666C7870786C6600, // K
        64'h6060606060607E00, // L
        64'h63777F6B63636300, // M
        64'h66767E7E6E666600, // N
        64'h3C66666666663C00, // O
        64'h7C66667C60606000, // P
        64'h3C666666663C0E00, // Q
        64'h7C66667C786C6600, // R
        64'h3C66603C06663C00, // S
        64'h7E18181818181800, // T
        64'h6666666666663C00, // U
        64'h66666666663C1800, // V
        64'h6363636B7F776300, // W
        64'h66663C183C666600, // X
        64'h6666663C18181800, // Y
        64'h7E060C1830607E00, // Z
        64'h0000000000000000  // space
    };

endpackage

// File: rtl/char_font_rom.sv
// rtl/char_font_rom.sv - synchronous font ROM returning one glyph row per clock
module char_font_rom
    import char_pkg::*;
(
    input  logic               clk,
    input  logic [CODE_W-1:0]  code,
    input  logic [2:0]         row,
    output logic [GLYPH_W-1:0] row_bits
);

    logic [63:0]        glyph;
    logic [GLYPH_W-1:0] rows [GLYPH_H];

    // Codes past the font table render as an empty cell
    always_comb begin
        glyph = '0;
        if (int'(code) < NUM_GLYPHS) begin
            glyph = FONT[code];
        end
    end

    always_comb begin
        for (int i = 0; i < GLYPH_H; i++) begin
            rows[i] = glyph[63-8*i -: 8];
        end
    end

    always_ff @(posedge clk) begin
        row_bits <= rows[row];
    end

endmodule

// File: rtl/char_string_renderer.sv
// rtl/char_string_renderer.sv - scaled 8x8 text row renderer with double-buffered codes and blink
module char_string_renderer
    import char_pkg::*;
#(
    parameter  int CHARS        = 4,
    parameter  int SCALE_LOG2   = 2,
    parameter  int BLINK_FRAMES = 30,
    localparam int IDX_W        = (CHARS > 1) ? $clog2(CHARS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        start_x,
    input  logic [9:0]        start_y,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [CODE_W-1:0] wr_code,
    input  logic              blink_en,
    output logic              display
);

    localparam int              CELL_SH  = 3 + SCALE_LOG2;
    localparam logic [10:0]     REGION_W = 11'(CHARS << CELL_SH);
    localparam logic [10:0]     REGION_H = 11'(GLYPH_H << SCALE_LOG2);
    localparam int              CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CODE_W-1:0] pending     [CHARS];
    logic [CODE_W-1:0] pending_nxt [CHARS];
    logic [CODE_W-1:0] active      [CHARS];

    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;

    logic [10:0]      dx;
    logic [10:0]      dy;
    logic             in_region_c;
    logic [IDX_W-1:0] idx_c;
    logic [2:0]       col_c;
    logic [2:0]       row_c;

    logic             s1_in;
    logic [IDX_W-1:0] s1_idx;
    logic [2:0]       s1_col;
    logic [2:0]       s1_row;
    logic [CODE_W-1:0] s1_code;

    logic             s2_in;
    logic [2:0]       s2_col;
    logic [GLYPH_W-1:0] row_bits;

    // A write in the same cycle as frame_start must reach the active buffer too
    always_comb begin
        pending_nxt = pending;
        if (wr_en && (32'(wr_idx) < CHARS)) begin
            pending_nxt[wr_idx] = wr_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHARS; i++) begin
                pending[i] <= CODE_SPACE;
                active[i]  <= CODE_SPACE;
            end
        end else begin
            pending <= pending_nxt;
            if (frame_start) begin
                active <= pending_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt == CNT_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // 11-bit differences plus explicit >= checks keep a region near 1023 from wrapping to x=0
    always_comb begin
        dx          = {1'b0, x} - {1'b0, start_x};
        dy          = {1'b0, y} - {1'b0, start_y};
        in_region_c = (x >= start_x) && (y >= start_y) && (dx < REGION_W) && (dy < REGION_H);
        idx_c       = IDX_W'(dx >> CELL_SH);
        col_c       = dx[SCALE_LOG2 +: 3];
        row_c       = dy[SCALE_LOG2 +: 3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_in  <= 1'b0;
            s1_idx <= '0;
            s1_col <= '0;
            s1_row <= '0;
        end else begin
            s1_in  <= in_region_c;
            s1_idx <= idx_c;
            s1_col <= col_c;
            s1_row <= row_c;
        end
    end

    always_comb begin
        s1_code = CODE_SPACE;
        if (32'(s1_idx) < CHARS) begin
            s1_code = active[s1_idx];
        end
    end

    char_font_rom u_font_rom (
        .clk      (clk),
        .code     (s1_code),
        .row      (s1_row),
        .row_bits (row_bits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_in  <= 1'b0;
            s2_col <= '0;
        end else begin
            s2_in  <= s1_in;
            s2_col <= s1_col;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display <= 1'b0;
        end else begin
            display <= s2_in & row_bits[3'd7 - s2_col] & (blink_phase | ~blink_en);
        end
    end

endmodule

// File: tb/tb_char_string_renderer.sv
// tb/tb_char_string_renderer.sv - scoreboard bench for char_string_renderer
module tb_char_string_renderer;

    logic       clk;
    logic       rst_n;
    logic [9:0] start_x;
    logic [9:0] start_y;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [5:0] wr_code;
    logic       blink_en;
    logic       display;

    typedef struct {
        int    due;
        bit    exp;
        string name;
    } exp_t;

    exp_t sb [$];
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    char_string_renderer #(
        .CHARS        (4),
        .SCALE_LOG2   (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_x     (start_x),
        .start_y     (start_y),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_code     (wr_code),
        .blink_en    (blink_en),
        .display     (display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic act, input bit exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: display=%0b required %0b (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compares each queued expectation on the falling edge of its due cycle
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due < cyc) begin
                chk_cnt++;
                $display("FAIL %s: expectation stale at cycle %0d, required cycle %0d", e.name, cyc, e.due);
            end else begin
                check(e.name, display, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int px, input int py, input bit e, input string n);
        exp_t t;
        x = 10'(px);
        y = 10'(py);
        t.due  = cyc + 3;
        t.exp  = e;
        t.name = n;
        sb.push_back(t);
        step();
    endtask

    task automatic wr(input int idx, input int code, input bit fs);
        wr_en       = 1'b1;
        wr_idx      = 2'(idx);
        wr_code     = 6'(code);
        frame_start = fs;
        step();
        wr_en       = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 10) begin
            step();
            k++;
        end
        if (sb.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain_timeout: %0d expectations outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    bit blink_exp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0; start_x = 10'd100; start_y = 10'd50; x = '0; y = '0;
        frame_start = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_code = '0; blink_en = 1'b0;
        repeat (3) step();
        check("reset_display", display, 1'b0);
        rst_n = 1'b1;
        step();

        for (int yy = 50; yy < 82; yy += 8)
            for (int xx = 100; xx < 228; xx += 4)
                pix(xx, yy, 1'b0, "blank_sweep");
        drain();

        // '0' in cell 0; idle pixels around the lit one pin the 3-clock latency
        wr(0, 0, 1'b0);
        fs_pulse();
        pix(0, 0, 1'b0, "latency_pre");
        pix(108, 50, 1'b1, "digit0_c2_r0");
        pix(0, 0, 1'b0, "latency_post");
        pix(100, 50, 1'b0, "digit0_c0_r0");
        pix(99, 50, 1'b0, "left_of_start");
        pix(104, 54, 1'b1, "digit0_c1_r1");
        pix(112, 54, 1'b0, "digit0_c3_r1");
        pix(108, 78, 1'b0, "digit0_r7");
        pix(108, 82, 1'b0, "below_region");
        pix(108, 49, 1'b0, "above_region");
        drain();

        wr(1, 11, 1'b0);
        pix(136, 50, 1'b0, "b_uncommitted");
        drain();
        fs_pulse();
        pix(136, 50, 1'b1, "b_c1_r0");
        pix(132, 50, 1'b0, "b_c0_r0");
        pix(152, 50, 1'b1, "b_c5_r0");
        pix(156, 50, 1'b0, "b_c6_r0");
        drain();

        wr(2, 10, 1'b1);
        pix(176, 50, 1'b1, "a_same_cycle_c3");
        pix(164, 50, 1'b0, "a_c0_r0");
        pix(168, 66, 1'b1, "a_c1_r4");
        drain();

        x = 10'd176; y = 10'd50;
        repeat (4) step();
        check("pre_reset_lit", display, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_line", display, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        fs_pulse();
        pix(108, 50, 1'b0, "post_reset_cell0");
        pix(136, 50, 1'b0, "post_reset_cell1");
        pix(176, 50, 1'b0, "post_reset_cell2");
        drain();

        wr(0, 0, 1'b1);
        blink_en = 1'b1;
        step();
        pix(108, 50, 1'b1, "blink_initial_visible");
        drain();
        for (int p = 0; p < 6; p++) begin
            x = '0; y = '0;
            fs_pulse();
            pix(108, 50, blink_exp[p], $sformatf("blink_after_pulse%0d", p + 1));
            drain();
        end
        pix(108, 50, 1'b0, "blink_hidden_before_drop");
        pix(108, 50, 1'b1, "blink_drop_next_clock");
        pix(108, 50, 1'b1, "blink_drop_hold");
        blink_en = 1'b0;
        pix(108, 50, 1'b1, "blink_off_visible");
        drain();
        blink_en = 1'b1;
        step();
        pix(108, 50, 1'b1, "blink_reenable_visible");
        drain();
        fs_pulse();
        pix(108, 50, 1'b1, "blink_counter_cleared");
        drain();
        blink_en = 1'b0;

        wr(1, 0, 1'b1);
        start_x = 10'd1000;
        pix(1020, 50, 1'b1, "edge_c5_r0");
        pix(1016, 50, 1'b1, "edge_c4_r0");
        pix(1003, 50, 1'b0, "edge_c0_r0");
        pix(999, 50, 1'b0, "edge_left_of_start");
        for (int xx = 0; xx < 28; xx++)
            pix(xx, 50, 1'b0, $sformatf("no_alias_x%0d", xx));
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
